// File: rtl/main_core_if.sv
// Debug/state observation bundle of the accumulator core.
interface main_core_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] out_port;
    logic              zero;
    logic              carry;
    logic              halted;

    modport master (output pc, acc, out_port, zero, carry, halted);
    modport slave  (input  pc, acc, out_port, zero, carry, halted);
endinterface

// File: rtl/main_core.sv
// Single-cycle accumulator processor with an internal parameterised program ROM.
// One instruction {opcode[3:0], imm[DATA_W-1:0]} is committed per rising edge.
module main_core #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter logic [(2**ADDR_W)*(DATA_W+4)-1:0] PROG = {
        12'h000, 12'h000, 12'h000, 12'h000,
        12'hF00, 12'hA00, 12'h100, 12'h90A,
        12'h220, 12'h1F0, 12'h1FF, 12'h806,
        12'h308, 12'hA00, 12'h203, 12'h105 }
) (
    input  logic        clk,
    input  logic        reset,
    main_core_if.master dbg
);
    localparam int unsigned INSTR_W = DATA_W + 4;
    localparam int unsigned DEPTH   = 2**ADDR_W;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JC   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_out;
    logic                r_z;
    logic                r_c;

    logic [INSTR_W-1:0]  w_rom [DEPTH];
    logic [INSTR_W-1:0]  w_instr;
    logic [3:0]          w_op;
    logic [DATA_W-1:0]   w_imm;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_target;
    logic [DATA_W:0]     w_add;
    logic [DATA_W:0]     w_sub;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]   w_out_nxt;
    logic                w_z_nxt;
    logic                w_c_nxt;
    logic                w_upd_z;
    logic                w_halt_nxt;

    // Unpack the flat program parameter into addressable ROM words
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign w_rom[g] = PROG[g*INSTR_W +: INSTR_W];
    end

    assign w_instr  = w_rom[r_pc];
    assign w_op     = w_instr[INSTR_W-1 -: 4];
    assign w_imm    = w_instr[DATA_W-1:0];
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_target = w_imm[ADDR_W-1:0];
    assign w_add    = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_sub    = {1'b0, r_acc} - {1'b0, w_imm};

    // Decode and execute: compute next architectural state for the current instruction
    always_comb begin
        w_pc_nxt   = w_pc_inc;
        w_acc_nxt  = r_acc;
        w_out_nxt  = r_out;
        w_z_nxt    = r_z;
        w_c_nxt    = r_c;
        w_upd_z    = 1'b0;
        w_halt_nxt = 1'b0;
        case (w_op)
            OP_LDI:  begin w_acc_nxt = w_imm;                                   w_upd_z = 1'b1; end
            OP_ADDI: begin {w_c_nxt, w_acc_nxt} = w_add;                        w_upd_z = 1'b1; end
            OP_SUBI: begin w_acc_nxt = w_sub[DATA_W-1:0]; w_c_nxt = w_sub[DATA_W]; w_upd_z = 1'b1; end
            OP_ANDI: begin w_acc_nxt = r_acc & w_imm; w_c_nxt = 1'b0;           w_upd_z = 1'b1; end
            OP_ORI:  begin w_acc_nxt = r_acc | w_imm; w_c_nxt = 1'b0;           w_upd_z = 1'b1; end
            OP_XORI: begin w_acc_nxt = r_acc ^ w_imm; w_c_nxt = 1'b0;           w_upd_z = 1'b1; end
            OP_JMP:  w_pc_nxt = w_target;
            OP_JZ:   if (r_z) w_pc_nxt = w_target;
            OP_JC:   if (r_c) w_pc_nxt = w_target;
            OP_OUT:  w_out_nxt = r_acc;
            OP_SHL:  begin
                w_c_nxt   = r_acc[DATA_W-1];
                w_acc_nxt = {r_acc[DATA_W-2:0], 1'b0};
                w_upd_z   = 1'b1;
            end
            OP_SHR:  begin
                w_c_nxt   = r_acc[0];
                w_acc_nxt = {1'b0, r_acc[DATA_W-1:1]};
                w_upd_z   = 1'b1;
            end
            OP_HLT:  begin
                w_pc_nxt   = r_pc;
                w_halt_nxt = 1'b1;
            end
            default: ;
        endcase
        if (w_upd_z) begin
            w_z_nxt = (w_acc_nxt == '0);
        end
    end

    // Commit one instruction per edge while running; everything freezes once halted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_pc    <= w_pc_nxt;
            r_acc   <= w_acc_nxt;
            r_out   <= w_out_nxt;
            r_z     <= w_z_nxt;
            r_c     <= w_c_nxt;
            r_state <= w_halt_nxt ? ST_HALT : ST_RUN;
        end
    end

    assign dbg.pc       = r_pc;
    assign dbg.acc      = r_acc;
    assign dbg.out_port = r_out;
    assign dbg.zero     = r_z;
    assign dbg.carry    = r_c;
    assign dbg.halted   = (r_state == ST_HALT);
endmodule

// File: tb/tb_main_core.sv
// Bench for main_core: directed table on the default program, ROM-override unit
// checks, and random reset pulses on default and pseudo-random programs vs a model.
module tb_main_core;
    // Pseudo-random program built at elaboration; HLT only allowed near the top.
    function automatic logic [191:0] gen_prog(input int unsigned seed);
        logic [191:0] p;
        int unsigned  s;
        logic [3:0]   op;
        s = seed;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            s  = s * 32'd1103515245 + 32'd12345;
            op = 4'(s >> 24);
            if (op == 4'hF && i < 12) op = 4'h2;
            p[i*12 +: 12] = {op, 8'(s >> 8)};
        end
        return p;
    endfunction

    localparam logic [191:0] PROG_B = {{15{12'h000}}, 12'h301};
    localparam logic [191:0] PROG_C = gen_prog(32'h1234_5678);

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    main_core_if if_a ();
    main_core_if if_b ();
    main_core_if if_c ();

    main_core                    u_a (.clk(clk), .reset(rst_a), .dbg(if_a));
    main_core #(.PROG(PROG_B))   u_b (.clk(clk), .reset(rst_b), .dbg(if_b));
    main_core #(.PROG(PROG_C))   u_c (.clk(clk), .reset(rst_c), .dbg(if_c));

    typedef struct { int pc; int acc; int outp; int z; int c; int h; } mstate_t;
    typedef struct { int edges; mstate_t exp; string name; } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int prog_a [16];

    function automatic mstate_t m_reset();
        mstate_t s;
        s = '{0, 0, 0, 0, 0, 0};
        return s;
    endfunction

    // Architectural model: one instruction word applied to the state with integer arithmetic.
    function automatic mstate_t m_step(input mstate_t s, input int ins);
        int op, imm, npc, t;
        mstate_t n;
        n = s;
        if (s.h != 0) return n;
        op  = ins / 256;
        imm = ins % 256;
        npc = (s.pc + 1) % 16;
        case (op)
            1:  begin n.acc = imm; n.z = (imm == 0); end
            2:  begin t = s.acc + imm; n.c = (t > 255); n.acc = t % 256; n.z = (n.acc == 0); end
            3:  begin n.c = (s.acc < imm); n.acc = (s.acc - imm + 256) % 256; n.z = (n.acc == 0); end
            4:  begin n.acc = s.acc & imm; n.c = 0; n.z = (n.acc == 0); end
            5:  begin n.acc = s.acc | imm; n.c = 0; n.z = (n.acc == 0); end
            6:  begin n.acc = s.acc ^ imm; n.c = 0; n.z = (n.acc == 0); end
            7:  npc = imm % 16;
            8:  if (s.z != 0) npc = imm % 16;
            9:  if (s.c != 0) npc = imm % 16;
            10: n.outp = s.acc;
            11: begin n.c = (s.acc >= 128); n.acc = (s.acc * 2) % 256; n.z = (n.acc == 0); end
            12: begin n.c = s.acc % 2; n.acc = s.acc / 2; n.z = (n.acc == 0); end
            15: begin n.h = 1; npc = s.pc; end
            default: ;
        endcase
        n.pc = npc;
        return n;
    endfunction

    function automatic mstate_t get_a();
        mstate_t s;
        s = '{int'(if_a.pc), int'(if_a.acc), int'(if_a.out_port),
              int'(if_a.zero), int'(if_a.carry), int'(if_a.halted)};
        return s;
    endfunction

    function automatic mstate_t get_b();
        mstate_t s;
        s = '{int'(if_b.pc), int'(if_b.acc), int'(if_b.out_port),
              int'(if_b.zero), int'(if_b.carry), int'(if_b.halted)};
        return s;
    endfunction

    function automatic mstate_t get_c();
        mstate_t s;
        s = '{int'(if_c.pc), int'(if_c.acc), int'(if_c.out_port),
              int'(if_c.zero), int'(if_c.carry), int'(if_c.halted)};
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input mstate_t a, input mstate_t e);
        chk({tag, ".pc"},       a.pc,   e.pc);
        chk({tag, ".acc"},      a.acc,  e.acc);
        chk({tag, ".out_port"}, a.outp, e.outp);
        chk({tag, ".zero"},     a.z,    e.z);
        chk({tag, ".carry"},    a.c,    e.c);
        chk({tag, ".halted"},   a.h,    e.h);
    endtask

    vec_t    vecs [11];
    mstate_t ma, mc, mb;

    initial begin
        prog_a = '{'h105, 'h203, 'hA00, 'h308, 'h806, 'h1FF, 'h1F0, 'h220,
                   'h90A, 'h100, 'hA00, 'hF00, 'h000, 'h000, 'h000, 'h000};
        //            edges  pc   acc   out  z  c  h
        vecs[0]  = '{1,  '{1,  'h05, 'h00, 0, 0, 0}, "e1_ldi"};
        vecs[1]  = '{1,  '{2,  'h08, 'h00, 0, 0, 0}, "e2_addi"};
        vecs[2]  = '{1,  '{3,  'h08, 'h08, 0, 0, 0}, "e3_out"};
        vecs[3]  = '{1,  '{4,  'h00, 'h08, 1, 0, 0}, "e4_subi"};
        vecs[4]  = '{1,  '{6,  'h00, 'h08, 1, 0, 0}, "e5_jz"};
        vecs[5]  = '{1,  '{7,  'hF0, 'h08, 0, 0, 0}, "e6_ldi"};
        vecs[6]  = '{1,  '{8,  'h10, 'h08, 0, 1, 0}, "e7_addi_c"};
        vecs[7]  = '{1,  '{10, 'h10, 'h08, 0, 1, 0}, "e8_jc"};
        vecs[8]  = '{1,  '{11, 'h10, 'h10, 0, 1, 0}, "e9_out"};
        vecs[9]  = '{1,  '{11, 'h10, 'h10, 0, 1, 1}, "e10_hlt"};
        vecs[10] = '{10, '{11, 'h10, 'h10, 0, 1, 1}, "halt_hold"};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_hold_a", get_a(), m_reset());
        cmp("reset_hold_b", get_b(), m_reset());

        // Directed walk through the default program
        rst_a = 1'b1;
        foreach (vecs[i]) begin
            repeat (vecs[i].edges) @(negedge clk);
            cmp(vecs[i].name, get_a(), vecs[i].exp);
        end

        // Mid-run asynchronous reset restarts from address 0
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_a = 1'b0;
        #1 cmp("async_reset_a", get_a(), m_reset());
        #1 rst_a = 1'b1;
        @(negedge clk);
        cmp("restart_a", get_a(), '{1, 'h05, 'h00, 0, 0, 0});

        // ROM override: SUBI 01 on zero, then NOPs wrapping past address 15
        rst_b = 1'b1;
        @(negedge clk);
        cmp("subi_borrow", get_b(), '{1, 'hFF, 'h00, 0, 1, 0});
        repeat (15) @(negedge clk);
        cmp("pc_wrap", get_b(), '{0, 'hFF, 'h00, 0, 1, 0});
        @(negedge clk);
        cmp("subi_again", get_b(), '{1, 'hFE, 'h00, 0, 0, 0});

        // Random reset pulses on default and pseudo-random programs, checked every cycle
        rst_a = 1'b0; rst_c = 1'b0;
        ma = m_reset(); mc = m_reset();
        @(negedge clk);
        rst_a = 1'b1; rst_c = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            ma = m_step(ma, prog_a[ma.pc]);
            mc = m_step(mc, int'(PROG_C[mc.pc*12 +: 12]));
            @(negedge clk);
            cmp("rand_a", get_a(), ma);
            cmp("rand_c", get_c(), mc);
            if ($urandom_range(19, 0) == 0) begin
                #1 rst_a = 1'b0; rst_c = 1'b0;
                #1 cmp("rand_rst_a", get_a(), m_reset());
                cmp("rand_rst_c", get_c(), m_reset());
                ma = m_reset(); mc = m_reset();
                #1 rst_a = 1'b1; rst_c = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
